// File: rtl/reset_ctrl_pkg.sv
// Shared types and defaults for the staged reset controller.
package reset_ctrl_pkg;

  localparam int STRETCH_W       = 5;
  localparam int FILT_CYCLES_DEF = 2;
  localparam int STRETCH_DEF     = 5;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT0,
    ST_WAIT1,
    ST_WAIT2,
    ST_RUN
  } rst_state_e;

  // Output pattern {rst0, rst1, rst2} asserted while in a given state.
  function automatic logic [2:0] state_outputs(input rst_state_e s);
    logic [2:0] o;
    o = 3'b111;
    case (s)
      ST_WAIT1: o = 3'b011;
      ST_WAIT2: o = 3'b001;
      ST_RUN:   o = 3'b000;
      default:  o = 3'b111;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop synchronizer for an asynchronous level; cleared by the block reset.
module reset_sync (
  input  logic clk,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (srst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/reset_controller_top.sv
// Reset controller: filtered primary request plus raw auxiliary request drive a
// staged release of three domain resets, each spaced STRETCH cycles apart.
module reset_controller_top
  import reset_ctrl_pkg::*;
#(
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int STRETCH     = STRETCH_DEF
) (
  input  logic clk,
  input  logic filt_rst,
  input  logic i_rst,
  input  logic i_aux_rst,
  input  logic filt_clk,
  output logic o_rst0_sync,
  output logic o_rst1_sync,
  output logic o_rst2_sync
);

  localparam logic [3:0]           FILT_MAX     = 4'(FILT_CYCLES);
  localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(STRETCH - 1);

  logic rst_s;
  logic aux_s;

  reset_sync u_sync_rst (
    .clk    (clk),
    .srst_i (filt_rst),
    .d_i    (i_rst),
    .q_o    (rst_s)
  );

  reset_sync u_sync_aux (
    .clk    (clk),
    .srst_i (filt_rst),
    .d_i    (i_aux_rst),
    .q_o    (aux_s)
  );

  logic [3:0]           filt_cnt_q, filt_cnt_d;
  logic                 filt_req;
  logic                 req;
  rst_state_e           state_q, state_d;
  logic [STRETCH_W-1:0] stretch_q, stretch_d;
  logic [2:0]           rst_q, rst_d;

  // The request qualifies on the cycle the updated count reaches FILT_CYCLES,
  // so a pulse of exactly FILT_CYCLES synced-high cycles is accepted.
  always_comb begin
    filt_cnt_d = filt_cnt_q;
    if (!rst_s) begin
      filt_cnt_d = 4'd0;
    end else if (!filt_clk && (filt_cnt_q != FILT_MAX)) begin
      filt_cnt_d = filt_cnt_q + 4'd1;
    end
    filt_req = rst_s && (filt_cnt_d == FILT_MAX);
    req      = filt_req | aux_s;
  end

  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    if (req) begin
      state_d   = ST_HOLD;
      stretch_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d   = ST_WAIT0;
          stretch_d = '0;
        end
        ST_WAIT0, ST_WAIT1, ST_WAIT2: begin
          if (stretch_q == STRETCH_LAST) begin
            stretch_d = '0;
            case (state_q)
              ST_WAIT0: state_d = ST_WAIT1;
              ST_WAIT1: state_d = ST_WAIT2;
              default:  state_d = ST_RUN;
            endcase
          end else begin
            stretch_d = stretch_q + STRETCH_W'(1);
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: begin
          state_d   = ST_HOLD;
          stretch_d = '0;
        end
      endcase
    end
    rst_d = state_outputs(state_d);
  end

  always_ff @(posedge clk) begin
    if (filt_rst) begin
      filt_cnt_q <= 4'd0;
      state_q    <= ST_WAIT0;
      stretch_q  <= '0;
      rst_q      <= 3'b111;
    end else begin
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      stretch_q  <= stretch_d;
      rst_q      <= rst_d;
    end
  end

  assign o_rst0_sync = rst_q[2];
  assign o_rst1_sync = rst_q[1];
  assign o_rst2_sync = rst_q[0];

endmodule

// File: tb/tb_reset_controller_top.sv
// Bench for reset_controller_top: directed scenarios then random pulses, every
// cycle compared against a timeline model of the reset release sequence.
module tb_reset_controller_top;

  localparam int F = 2;
  localparam int S = 5;

  logic clk = 1'b0;
  logic filt_rst = 1'b0;
  logic i_rst = 1'b0;
  logic i_aux_rst = 1'b0;
  logic filt_clk = 1'b0;
  logic o_rst0_sync, o_rst1_sync, o_rst2_sync;

  int checks = 0;
  int errors = 0;

  bit rq[$];
  bit aq[$];
  int run;
  int t;
  bit hold;
  logic [2:0] exp_out;

  always #5 clk = ~clk;

  reset_controller_top dut (
    .clk         (clk),
    .filt_rst    (filt_rst),
    .i_rst       (i_rst),
    .i_aux_rst   (i_aux_rst),
    .filt_clk    (filt_clk),
    .o_rst0_sync (o_rst0_sync),
    .o_rst1_sync (o_rst1_sync),
    .o_rst2_sync (o_rst2_sync)
  );

  // Model: synced inputs are the raw inputs two edges late; t counts edges
  // since the release sequence started, and each output drops at its own
  // multiple of S.
  function automatic void model_edge(input bit r, input bit a, input bit fc, input bit fr);
    bit sr, sa, req;
    if (fr) begin
      rq = {1'b0, 1'b0};
      aq = {1'b0, 1'b0};
      run = 0;
      t = 0;
      hold = 1'b0;
    end else begin
      sr = rq.pop_front();
      rq.push_back(r);
      sa = aq.pop_front();
      aq.push_back(a);
      if (!sr) run = 0;
      else if (!fc && run < F) run++;
      req = (sr && run == F) || sa;
      if (req) hold = 1'b1;
      else if (hold) begin
        hold = 1'b0;
        t = 0;
      end else if (t < 3 * S) t++;
    end
    exp_out = hold ? 3'b111 : {t < S, t < 2 * S, t < 3 * S};
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit a, input bit fc, input bit fr);
    i_rst = r;
    i_aux_rst = a;
    filt_clk = fc;
    filt_rst = fr;
    @(posedge clk);
    model_edge(r, a, fc, fr);
    @(negedge clk);
    $display("cyc rst=%0b aux=%0b fclk=%0b frst=%0b out=%b exp=%b", r, a, fc, fr,
             {o_rst0_sync, o_rst1_sync, o_rst2_sync}, exp_out);
    check("model", {o_rst0_sync, o_rst1_sync, o_rst2_sync}, exp_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [2:0] outs();
    return {o_rst0_sync, o_rst1_sync, o_rst2_sync};
  endfunction

  initial begin
    rq = {1'b0, 1'b0};
    aq = {1'b0, 1'b0};
    run = 0;
    t = 0;
    hold = 1'b0;
    exp_out = 3'b111;

    // Block reset and staged release
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_state", outs(), 3'b111);
    idle(4);
    check("rel_pre0", outs(), 3'b111);
    idle(1);
    check("rel0_at5", outs(), 3'b011);
    idle(5);
    check("rel1_at10", outs(), 3'b001);
    idle(5);
    check("rel2_at15", outs(), 3'b000);
    idle(3);

    // One-cycle glitch is rejected
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    check("glitch_1cyc", outs(), 3'b000);

    // Two-cycle pulse is a valid request
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("pulse_2cyc", outs(), 3'b111);
    idle(20);
    check("pulse_2cyc_rel", outs(), 3'b000);

    // Auxiliary request, unfiltered
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("aux_hold", outs(), 3'b111);
    idle(20);
    check("aux_rel", outs(), 3'b000);

    // Abort during WAIT1
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30 && exp_out != 3'b011; i++) idle(1);
    check("wait1_reached", outs(), 3'b011);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("abort_wait1", outs(), 3'b111);
    idle(25);
    check("abort_rel", outs(), 3'b000);

    // Stalled filter ignores a 3-cycle pulse
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    check("stall_no_req", outs(), 3'b000);

    // Long request saturates the filter and holds
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("long_hold", outs(), 3'b111);
    idle(25);
    check("long_rel", outs(), 3'b000);

    // Block reset wins over a simultaneous aux request
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_priority", outs(), 3'b111);
    idle(20);
    check("rst_priority_rel", outs(), 3'b000);

    // Randomized pulses
    for (int seg = 0; seg < 80; seg++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        bit r, a, fc, fr;
        r  = (kind <= 4) || (kind == 8);
        a  = (kind == 5) || (kind == 6) || (kind == 8);
        fc = ($urandom_range(0, 3) == 0);
        fr = (kind == 9) && (i == 0);
        step(r, a, fc, fr);
      end
      idle($urandom_range(0, 22));
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_controller_top.md
RESET_CONTROLLER_TOP -- requirements
Module: reset_controller_top

Interface
REQ-001 Parameter FILT_CYCLES, default 2: consecutive synchronized-high cycles on i_rst (legal 1..15) that count as a valid reset request.
REQ-002 Parameter STRETCH, default 5: cycles between successive output-reset releases (legal 5..16).
REQ-003 clk  input  1  sole clock; all flops rise on posedge clk.
REQ-004 filt_rst  input  1  block reset, synchronous, active-high.
REQ-005 i_rst  input  1  primary reset request, asynchronous to clk, glitch-filtered, active-high.
REQ-006 i_aux_rst  input  1  auxiliary reset request, asynchronous, not filtered, active-high.
REQ-007 filt_clk  input  1  filter stall, level, sampled on clk (not a clock); 1 freezes the filter counter, 0 runs it.
REQ-008 o_rst0_sync  output  1  first-released domain reset, active-high, registered.
REQ-009 o_rst1_sync  output  1  second-released domain reset, active-high, registered.
REQ-010 o_rst2_sync  output  1  last-released domain reset, active-high, registered.

Function
REQ-011 i_rst and i_aux_rst each pass through a 2-flop synchronizer; synced value valid 2 clk edges after the input changes.
REQ-012 Filter: counter increments on each cycle synced i_rst=1 and filt_clk=0, clears on synced i_rst=0, saturates at FILT_CYCLES.
REQ-013 filt_req=1 while counter==FILT_CYCLES and synced i_rst=1; shorter pulses produce no request.
REQ-014 Combined request req = filt_req OR synced i_aux_rst.
REQ-015 FSM states: HOLD, WAIT0, WAIT1, WAIT2, RUN; {rst0,rst1,rst2} = 111 in HOLD/WAIT0, 011 in WAIT1, 001 in WAIT2, 000 in RUN.
REQ-016 Any state with req=1 goes to HOLD next cycle and reloads stretch counter; HOLD stays while req=1.
REQ-017 HOLD with req=0 goes to WAIT0; WAIT0, WAIT1 and WAIT2 each last exactly STRETCH cycles, then advance WAIT0->WAIT1->WAIT2->RUN.
REQ-018 RUN is held until req=1.
REQ-019 req during WAIT0..WAIT2 aborts the release sequence: all outputs reassert the next cycle.
REQ-020 Outputs are monotonic during a release sequence: rst0 releases before rst1, rst1 before rst2, spaced exactly STRETCH cycles apart.
REQ-021 Stretch counter is 5 bits wide and never wraps: it is reloaded on each state entry.
REQ-022 Simultaneous i_rst and i_aux_rst behave as one request; the request ends when both synced inputs are low.

Reset
REQ-023 With filt_rst=1 at a clk edge: synchronizers cleared, filter counter 0, stretch counter 0, FSM = WAIT0, all outputs = 1.
REQ-024 After filt_rst falls with no request: o_rst0_sync falls STRETCH cycles later, o_rst1_sync STRETCH cycles after that, o_rst2_sync STRETCH cycles after that.
REQ-025 filt_rst takes priority over every other input at the same edge.

Structure
REQ-026 Package reset_ctrl_pkg holds the FSM state enum, the stretch-counter width constant (5) and the default FILT_CYCLES and STRETCH values.
REQ-027 Sub-module reset_sync implements the 2-flop synchronizer and is instantiated twice (i_rst, i_aux_rst).
REQ-028 The top-level module holds the filter, the FSM and the output registers; no latches and no combinational outputs.

Verification
REQ-029 Hold filt_rst=1 for 2 cycles, then release -> outputs 111, then 011 at +5 cycles, 001 at +10, 000 at +15.
REQ-030 i_rst high for 1 cycle (10 ns at 100 MHz) -> no request; outputs stay 000.
REQ-031 i_rst high for 2 cycles -> outputs 111 within 4 cycles, then staged release at 5-cycle spacing.
REQ-032 i_aux_rst high for 10 cycles -> outputs 111 within 3 cycles, held until release, then the 5/10/15-cycle release sequence.
REQ-033 i_rst valid request re-issued while the FSM is in WAIT1 -> outputs 111 the next cycle and the sequence restarts from HOLD.
REQ-034 filt_clk=1 during a 3-cycle i_rst pulse -> filter counter frozen, no request, outputs unchanged.
